bsg_scan_xor_unpack: RTL
========================

# bsg_scan_xor_unpack

Streaming inverse of the XOR prefix scan used in the datapath. It accepts scanned words of a multi-word packet and recovers the original bits, o[k] = s[k] ^ s[k+1], carrying the scan boundary across word edges within a packet. It sits on the receive side of any link whose sender applied a packet-wide high-to-low XOR scan. The block has a valid/ready handshake on both sides and a 2-entry output buffer.

## Interface
Parameters:
- width_p, 16, word width in bits; must be ≥ 2.
- idx_width_p, 8, width of the per-packet word index output.

Ports:
- clk_i  in  1  clock; the only clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- v_i  in  1  input word valid.
- data_i  in  width_p  scanned input word.
- last_i  in  1  marks the final word of a packet.
- ready_o  out  1  input can be accepted; a word is accepted when v_i & ready_o.
- v_o  out  1  output word valid.
- data_o  out  width_p  recovered word.
- last_o  out  1  last flag of the output word.
- idx_o  out  idx_width_p  position of the output word within its packet.
- ready_i  in  1  downstream accepts; a word is consumed when v_o & ready_i.

## Operation
- Packet bit order: word 0 is most significant; within a word, bit width_p-1 is most significant. The sender's scan runs from the packet MSB downward.
- Decode of an accepted word s:
  - o[k] = s[k] ^ s[k+1] for k < width_p-1.
  - o[width_p-1] = s[width_p-1] ^ carry.
- carry register:
  - On every accepted word, carry ← s[0].
  - If last_i is set on that accepted word, carry ← 0 instead.
  - Reset value is 0. The first word of every packet therefore uses carry 0.
- Index counter:
  - Incremented on each accepted word; that word's idx is the pre-increment value.
  - Cleared to 0 after an accepted word with last_i set.
  - Saturates at 2^idx_width_p − 1 and does not wrap. Decoding is unaffected by saturation.
- Output buffer: 2-entry FIFO of {data, last, idx}, filled with decoded words in acceptance order.
  - ready_o = !full, derived from registered state only; it has no combinational path from ready_i.
  - v_o = !empty. Outputs are taken from the FIFO head.
  - Enqueue and dequeue in the same cycle are legal whenever not full. Occupancy is then unchanged and order is preserved.
  - When full, ready_o = 0. A dequeue in that cycle frees a slot, and ready_o rises the next cycle.
- v_i may be asserted regardless of ready_o. data_i and last_i must be held stable while v_i & !ready_o.

## Timing
- Reset values: ready_o = 1, v_o = 0, data_o = 0, last_o = 0, idx_o = 0. The FIFO is emptied and carry = 0, idx counter = 0.
- Reset asserted mid-packet discards all buffered words and the partial packet state. The first word after reset is decoded as the first word of a packet.
- Latency: a word accepted at edge N appears on v_o/data_o after edge N (registered), i.e. one cycle.
- Throughput: one word per cycle with ready_i held high. The buffer never fills in that case.
- Back-to-back packets need no bubble. A word accepted the cycle after a last word uses carry 0.

## Test plan
- Single-word packets (width 16):
  - s = 16'hFFFF, last = 1 -> data_o = 16'h8000, last_o = 1, idx_o = 0, one cycle later.
  - s = 16'h0001, last = 1 -> data_o = 16'h0001.
- Two-word packet:
  - Stimulus: 16'hFFFF (last = 0), then 16'hFFFF (last = 1).
  - Required: 16'h8000 (idx 0), then 16'h0000 (idx 1, last_o = 1).
- Packet boundary:
  - Stimulus: the two-word packet above, immediately followed by 16'hFFFF (last = 1).
  - Required: third output 16'h8000, idx 0. This proves carry is cleared.
- Backpressure:
  - Stimulus: ready_i = 0, offer 3 words.
  - Required: exactly 2 are accepted and ready_o = 0. On raising ready_i, outputs drain in order and ready_o returns to 1 one cycle after the first dequeue. No loss or duplication.
- Reset mid-packet:
  - Stimulus: accept 16'hFFFF (last = 0), pulse reset_n_i low for one cycle, then send 16'hFFFF (last = 1).
  - Required: v_o = 0 after reset, and the next output is 16'h8000 with idx 0.
- Random scoreboard: random packets of 1–300 words with random v_i/ready_i, compared against a software scan-inverse model. idx_o must saturate at 255.

Source files
------------

// File: rtl/bsg_scan_xor_unpack.sv
// Streaming inverse of a packet-wide high-to-low XOR prefix scan.
// Decodes o[k] = s[k] ^ s[k+1] across word edges and buffers results in a 2-entry FIFO.
module bsg_scan_xor_unpack #(
    parameter int width_p     = 16,
    parameter int idx_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    output logic                   last_o,
    output logic [idx_width_p-1:0] idx_o,
    input  logic                   ready_i
);

    typedef struct packed {
        logic [width_p-1:0]     data;
        logic                   last;
        logic [idx_width_p-1:0] idx;
    } entry_t;

    localparam logic [idx_width_p-1:0] idx_max_lp = '1;

    entry_t                 mem_q [2];
    entry_t                 mem_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   carry_q, carry_d;
    logic [idx_width_p-1:0] idx_q, idx_d;

    logic                   accept;
    logic                   deq;
    logic [width_p-1:0]     decoded;
    entry_t                 head;

    // Handshake status comes only from registered occupancy, never from ready_i.
    assign ready_o = (count_q != 2'd2);
    assign v_o     = (count_q != 2'd0);
    assign head    = mem_q[rd_ptr_q];
    assign data_o  = head.data;
    assign last_o  = head.last;
    assign idx_o   = head.idx;

    always_comb begin
        accept   = v_i & ready_o;
        deq      = v_o & ready_i;
        // Each bit XORs with its more-significant neighbour; the top bit uses the carried scan bit.
        decoded  = data_i ^ {carry_q, data_i[width_p-1:1]};

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        carry_d  = carry_q;
        idx_d    = idx_q;

        if (accept) begin
            mem_d[wr_ptr_q] = '{data: decoded, last: last_i, idx: idx_q};
            wr_ptr_d        = ~wr_ptr_q;
            carry_d         = last_i ? 1'b0 : data_i[0];
            if (last_i) begin
                idx_d = '0;
            end else if (idx_q != idx_max_lp) begin
                idx_d = idx_q + idx_width_p'(1);
            end
        end

        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({accept, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
        end
    end

endmodule
